// File: rtl/inst_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// inst_sequencer_pkg
// Shared definitions for the vending-machine instruction set. It holds the
// opcodes, the marker register and the 19-bit field positions. It also holds
// the sequencer state encoding and the decoded-field bundle that the decoder
// and the sequencer exchange.
// -----------------------------------------------------------------------------
package inst_sequencer_pkg;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_LDI   = 3'd7;
    localparam logic [3:0] REG_MARK = 4'hf;

    // Field positions inside the 19-bit instruction word.
    localparam int OP_HI  = 18;
    localparam int OP_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 12;
    localparam int RS_HI  = 11;
    localparam int RS_LO  = 8;
    localparam int RT_HI  = 7;
    localparam int RT_LO  = 4;
    localparam int IMM_HI = 11;
    localparam int IMM_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_ISSUE = 2'd2,
        ST_END   = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0]  alu_op;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [11:0] imm;
        logic        rf_we;
    } fields_t;

endpackage

// File: rtl/inst_sequencer_if.sv
// -----------------------------------------------------------------------------
// inst_sequencer_if
// Bundles the sequencer's control, ROM and decode signals.
//   master : the sequencer. It receives start, ex_ready and rom_dout. It drives
//            rom_addr, busy, done, err, issue_valid and the decoded fields.
//   slave  : the surroundings. These are the vend FSM, the ROM and the
//            register file/ALU.
// -----------------------------------------------------------------------------
interface inst_sequencer_if #(
    parameter int ADDR_W = 3,
    parameter int INST_W = 19
);
    logic              start;
    logic              ex_ready;
    logic [INST_W-1:0] rom_dout;
    logic [ADDR_W-1:0] rom_addr;
    logic              busy;
    logic              done;
    logic              err;
    logic              issue_valid;
    logic [2:0]        alu_op;
    logic [3:0]        rd;
    logic [3:0]        rs;
    logic [3:0]        rt;
    logic [11:0]       imm;
    logic              rf_we;

    modport master (
        input  start, ex_ready, rom_dout,
        output rom_addr, busy, done, err, issue_valid,
               alu_op, rd, rs, rt, imm, rf_we
    );

    modport slave (
        output start, ex_ready, rom_dout,
        input  rom_addr, busy, done, err, issue_valid,
               alu_op, rd, rs, rt, imm, rf_we
    );
endinterface

// File: rtl/inst_sequencer_decode.sv
// -----------------------------------------------------------------------------
// inst_decode
// Purely combinational split of one ROM word into its register-file/ALU fields.
//   inst_i      : raw instruction word
//   fields_o    : alu_op/rd/rs/rt/imm plus the write enable for rd
//   is_marker_o : word is the header/end marker (LDI into r15)
// A marker never writes, so rf_we is simply the inverse of is_marker.
// -----------------------------------------------------------------------------
module inst_decode
    import inst_sequencer_pkg::*;
#(
    parameter int INST_W = 19
) (
    input  logic [INST_W-1:0] inst_i,
    output fields_t           fields_o,
    output logic              is_marker_o
);
    assign fields_o.alu_op = inst_i[OP_HI:OP_LO];
    assign fields_o.rd     = inst_i[RD_HI:RD_LO];
    assign fields_o.rs     = inst_i[RS_HI:RS_LO];
    assign fields_o.rt     = inst_i[RT_HI:RT_LO];
    // imm overlaps rs/rt; only LDI interprets it.
    assign fields_o.imm    = inst_i[IMM_HI:IMM_LO];

    assign is_marker_o     = (inst_i[OP_HI:OP_LO] == OP_LDI) &&
                             (inst_i[RD_HI:RD_LO] == REG_MARK);
    assign fields_o.rf_we  = !is_marker_o;
endmodule

// File: rtl/inst_sequencer.sv
// -----------------------------------------------------------------------------
// inst_sequencer
// Fetch/decode stage. On a start pulse it checks the header marker at address
// 0. It then issues words from address 1 upward, one per cycle when ex_ready
// is high, until it meets the end marker. At that point it pulses done.
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : inst_sequencer_if.master. This is start/ex_ready/rom_dout in, and
//          rom_addr, status pulses and registered decode fields out.
// A missing header, or running off the last address without an end marker,
// ends the program with an err pulse instead of done.
// -----------------------------------------------------------------------------
module inst_sequencer
    import inst_sequencer_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int INST_W = 19
) (
    input  logic             clk,
    input  logic             rst,
    inst_sequencer_if.master bus
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              issue_q, issue_d;
    fields_t           fld_q, fld_d;

    fields_t           dec;
    logic              is_marker;

    inst_decode #(.INST_W(INST_W)) u_decode (
        .inst_i      (bus.rom_dout),
        .fields_o    (dec),
        .is_marker_o (is_marker)
    );

    always_comb begin
        // NOTE: every next-state signal gets a default before the case so
        // that no path leaves one unassigned, which would infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        issue_d      = 1'b0;
        fld_d        = fld_q;     // decode fields hold between issues
        fld_d.rf_we  = 1'b0;      // write enable lives only with issue_valid

        case (state_q)
            ST_IDLE: begin
                pc_d = '0;
                if (bus.start) begin
                    busy_d  = 1'b1;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (is_marker) begin
                    pc_d    = ADDR_W'(1);
                    state_d = ST_ISSUE;
                end else begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (bus.ex_ready) begin
                    if (is_marker) begin
                        state_d = ST_END;
                    end else begin
                        fld_d   = dec;
                        issue_d = 1'b1;
                        // The last word is still issued. Without an end
                        // marker the run then aborts instead of wrapping.
                        if (&pc_q) begin
                            err_d   = 1'b1;
                            busy_d  = 1'b0;
                            pc_d    = '0;
                            state_d = ST_IDLE;
                        end else begin
                            pc_d = pc_q + ADDR_W'(1);
                        end
                    end
                end
            end
            ST_END: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pc_d    = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments, so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: the decode field registers are reset too, because they
            // are directly visible outputs and must read 0 after reset.
            state_q <= ST_IDLE;
            pc_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            issue_q <= 1'b0;
            fld_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            issue_q <= issue_d;
            fld_q   <= fld_d;
        end
    end

    assign bus.rom_addr    = pc_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.issue_valid = issue_q;
    assign bus.alu_op      = fld_q.alu_op;
    assign bus.rd          = fld_q.rd;
    assign bus.rs          = fld_q.rs;
    assign bus.rt          = fld_q.rt;
    assign bus.imm         = fld_q.imm;
    assign bus.rf_we       = fld_q.rf_we;
endmodule

// File: tb/tb_inst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_inst_sequencer
// Runs directed and randomized ROM programs through inst_sequencer. It compares
// every cycle against a program-level reference. That reference walks the ROM
// from the header and advances one word per ready cycle. It predicts issues,
// the address, busy, and the final done/err pulse.
// -----------------------------------------------------------------------------
module tb_inst_sequencer;
    localparam int ADDR_W = 3;
    localparam int INST_W = 19;
    localparam int MAXC   = 80;

    logic clk;
    logic rst;

    inst_sequencer_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) sif ();

    inst_sequencer #(.ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    logic [INST_W-1:0] rom [8];
    assign sif.rom_dout = rom[sif.rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference timeline. Index k is the observation after the k-th edge,
    // where edge 0 samples start.
    bit                rdy    [MAXC];
    bit                e_busy [MAXC];
    bit                e_iv   [MAXC];
    bit                e_done [MAXC];
    bit                e_err  [MAXC];
    logic [ADDR_W-1:0] e_addr [MAXC];
    logic [INST_W-1:0] e_word [MAXC];
    logic [INST_W-1:0] e_fld  [MAXC];
    int                e_end;
    logic [INST_W-1:0] last_word;

    localparam logic [INST_W-1:0] MARK = 19'h7f000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_mark(input logic [INST_W-1:0] w);
        return (w[18:16] == 3'd7) && (w[15:12] == 4'hf);
    endfunction

    // Walks the program: header check, then one word per ready cycle.
    task automatic build_model();
        int a;
        int k;
        logic [INST_W-1:0] cur;
        for (int i = 0; i < MAXC; i++) begin
            e_busy[i] = 0; e_iv[i] = 0; e_done[i] = 0; e_err[i] = 0;
            e_addr[i] = '0; e_word[i] = '0;
        end
        e_busy[0] = 1;
        e_end = 0;
        if (!is_mark(rom[0])) begin
            e_err[1] = 1;
            e_end    = 1;
        end else begin
            a = 1;
            e_busy[1] = 1;
            e_addr[1] = ADDR_W'(a);
            k = 2;
            while (e_end == 0 && k < MAXC - 2) begin
                e_busy[k] = 1;
                e_addr[k] = ADDR_W'(a);
                if (rdy[k]) begin
                    if (is_mark(rom[a])) begin
                        e_done[k+1] = 1;
                        e_end = k + 1;
                    end else begin
                        e_iv[k]   = 1;
                        e_word[k] = rom[a];
                        if (a == 7) begin
                            e_err[k]  = 1;
                            e_busy[k] = 0;
                            e_addr[k] = '0;
                            e_end     = k;
                        end else begin
                            a++;
                            e_addr[k] = ADDR_W'(a);
                        end
                    end
                end
                k++;
            end
        end
        cur = last_word;
        for (int i = 0; i < MAXC; i++) begin
            if (e_iv[i]) cur = e_word[i];
            e_fld[i] = cur;
        end
    endtask

    task automatic run_program(input string name, input bit stray,
                               output int n_iss, output int n_done, output int n_err,
                               output int done_at, output int err_at);
        logic [INST_W-1:0] w;
        build_model();
        n_iss = 0; n_done = 0; n_err = 0; done_at = -1; err_at = -1;
        check($sformatf("%s_model_ends", name), 32'(e_end > 0), 32'd1);
        sif.start    = 1'b1;
        sif.ex_ready = rdy[0];
        for (int k = 0; k <= e_end + 1; k++) begin
            @(posedge clk);
            @(negedge clk);
            w = e_fld[k];
            check($sformatf("%s_busy@%0d", name, k), 32'(sif.busy), 32'(e_busy[k]));
            check($sformatf("%s_addr@%0d", name, k), 32'(sif.rom_addr), 32'(e_addr[k]));
            check($sformatf("%s_iv@%0d", name, k), 32'(sif.issue_valid), 32'(e_iv[k]));
            check($sformatf("%s_we@%0d", name, k), 32'(sif.rf_we), 32'(e_iv[k]));
            check($sformatf("%s_done@%0d", name, k), 32'(sif.done), 32'(e_done[k]));
            check($sformatf("%s_err@%0d", name, k), 32'(sif.err), 32'(e_err[k]));
            check($sformatf("%s_fields@%0d", name, k),
                  {5'd0, sif.alu_op, sif.rd, sif.rs, sif.rt, sif.imm},
                  {5'd0, w[18:16], w[15:12], w[11:8], w[7:4], w[11:0]});
            if (sif.issue_valid) n_iss++;
            if (sif.done) begin n_done++; if (done_at < 0) done_at = k; end
            if (sif.err)  begin n_err++;  if (err_at < 0)  err_at = k;  end
            // Stray starts only while a program is still in flight.
            sif.start    = stray && (k + 1 <= e_end) &&
                           ((k + 1 == 2) || ($urandom_range(0, 2) == 0));
            sif.ex_ready = rdy[k+1];
        end
        sif.start = 1'b0;
        last_word = e_fld[e_end+1];
    endtask

    task automatic load_example();
        rom[0] = MARK; rom[1] = 19'h7100a; rom[2] = 19'h04140; rom[3] = MARK;
        for (int i = 4; i < 8; i++) rom[i] = 19'h00000;
    endtask

    task automatic all_ready();
        for (int i = 0; i < MAXC; i++) rdy[i] = 1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(sif.busy), 32'd0);
        check({tag, "_addr"}, 32'(sif.rom_addr), 32'd0);
        check({tag, "_iv"}, 32'(sif.issue_valid), 32'd0);
        check({tag, "_done"}, 32'(sif.done), 32'd0);
        check({tag, "_err"}, 32'(sif.err), 32'd0);
        check({tag, "_we"}, 32'(sif.rf_we), 32'd0);
        check({tag, "_fields"}, {5'd0, sif.alu_op, sif.rd, sif.rs, sif.rt, sif.imm}, 32'd0);
    endtask

    initial begin
        int n_iss, n_done, n_err, done_at, err_at;
        rst = 1'b1; sif.start = 1'b0; sif.ex_ready = 1'b0;
        last_word = '0;
        load_example();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Basic program: two issues, done five cycles after start.
        all_ready();
        run_program("ex1", 0, n_iss, n_done, n_err, done_at, err_at);
        check("ex1_issues", 32'(n_iss), 32'd2);
        check("ex1_done_at", 32'(done_at), 32'd5);
        check("ex1_no_err", 32'(n_err), 32'd0);

        // Three stall cycles while rom_addr=2 delay done by three.
        all_ready();
        rdy[3] = 0; rdy[4] = 0; rdy[5] = 0;
        run_program("stall", 0, n_iss, n_done, n_err, done_at, err_at);
        check("stall_issues", 32'(n_iss), 32'd2);
        check("stall_done_at", 32'(done_at), 32'd8);

        // Missing header.
        rom[0] = 19'h7100a;
        all_ready();
        run_program("nohdr", 0, n_iss, n_done, n_err, done_at, err_at);
        check("nohdr_err_at", 32'(err_at), 32'd1);
        check("nohdr_issues", 32'(n_iss), 32'd0);
        check("nohdr_done", 32'(n_done), 32'd0);

        // No end marker: seven issues, then err, no wrap.
        rom[0] = MARK;
        for (int i = 1; i < 8; i++) rom[i] = 19'(i * 19'h01111);
        all_ready();
        run_program("noend", 0, n_iss, n_done, n_err, done_at, err_at);
        check("noend_issues", 32'(n_iss), 32'd7);
        check("noend_err_at", 32'(err_at), 32'd8);
        check("noend_done", 32'(n_done), 32'd0);

        // A start pulsed mid-program is ignored.
        load_example();
        all_ready();
        run_program("stray", 1, n_iss, n_done, n_err, done_at, err_at);
        check("stray_done_cnt", 32'(n_done), 32'd1);
        check("stray_issues", 32'(n_iss), 32'd2);

        // Reset at rom_addr=2 aborts, then a fresh start runs fully.
        sif.start = 1'b1; sif.ex_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        sif.start = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        check("rstmid_addr_before", 32'(sif.rom_addr), 32'd2);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check_all_zero("rstmid");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            check("rstmid_no_end_pulse", {30'd0, sif.done, sif.err}, 32'd0);
            check("rstmid_idle", 32'(sif.busy), 32'd0);
        end
        last_word = '0;
        all_ready();
        run_program("rerun", 0, n_iss, n_done, n_err, done_at, err_at);
        check("rerun_issues", 32'(n_iss), 32'd2);
        check("rerun_done_at", 32'(done_at), 32'd5);

        // Randomized ROMs, ready patterns and stray starts.
        for (int t = 0; t < 20; t++) begin
            rom[0] = ($urandom_range(0, 9) < 8) ? MARK : 19'($urandom);
            for (int i = 1; i < 8; i++)
                rom[i] = ($urandom_range(0, 4) == 0) ? MARK : 19'($urandom);
            for (int i = 0; i < MAXC; i++)
                rdy[i] = (i >= 30) ? 1'b1 : ($urandom_range(0, 3) != 0);
            run_program($sformatf("rnd%0d", t), 1, n_iss, n_done, n_err, done_at, err_at);
            check($sformatf("rnd%0d_one_end", t), 32'(n_done + n_err), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
